// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Smallest digit count whose decimal range covers every BIN_W-bit value.
    function automatic int min_digits(input int bin_w);
        longint unsigned v;
        int              d;
        v = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// start/busy/done handshake plus result bus between a requester and the converter.
interface bin2bcd_if
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                          start;
    logic [BIN_W-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]             digit_en;

    modport master (output start, bin, input busy, done, bcd, digit_en);
    modport slave  (input start, bin, output busy, done, bcd, digit_en);
endinterface

// File: rtl/bcd_add3.sv
// Single-digit adjust for shift-and-add-3: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Optional macro LEADING_ZERO_BLANK_EN: blank display digits above the most significant nonzero one.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          clrn,
    bin2bcd_if.slave      bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;

    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    state_e            state_q;
    logic [BIN_W-1:0]  sreg_q;
    logic [SCR_W-1:0]  scratch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [SCR_W-1:0]  bcd_q;
    logic [DIGITS-1:0] en_q;

    logic [SCR_W-1:0]       adj;
    logic [SCR_W+BIN_W-1:0] shifted;
    logic [DIGITS-1:0]      en_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d_i (scratch_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .d_o (adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    assign shifted = {adj, sreg_q} << 1;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);

    // A digit is shown once any digit at or above it is nonzero; digit 0 always shows.
    always_comb begin
        logic seen;
        seen = 1'b0;
        en_d = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen    = seen | (|scratch_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
            en_d[i] = seen;
        end
        en_d[0] = 1'b1;
    end
`else
    localparam logic [DIGITS-1:0] EN_RST = '1;

    assign en_d = '1;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            en_q      <= EN_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sreg_q    <= bus.bin;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(BIN_W);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_q, sreg_q} <= shifted;
                    cnt_q               <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= DONE;
                end
                DONE: begin
                    bcd_q   <= scratch_q;
                    en_q    <= en_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.digit_en = en_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [DIGITS-1:0] EN_RST = 5'b00001;
`else
    localparam logic [DIGITS-1:0] EN_RST = 5'b11111;
`endif

    logic clk = 1'b0;
    logic clrn;
    int   checks = 0;
    int   passes = 0;

    logic [4*DIGITS-1:0] shown_bcd;
    logic [DIGITS-1:0]   shown_en;

    always #5 clk = ~clk;

    bin2bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_en(input int unsigned v);
        logic [DIGITS-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
        int unsigned p;
        r = 5'b00001;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            if (v >= p) r[i] = 1'b1;
            p = p * 10;
        end
`else
        r = '1;
        if (v > 0) r = '1;
`endif
        return r;
    endfunction

    task automatic run_one(input string name, input logic [BIN_W-1:0] v);
        int k, bcnt;
        bit moved;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 16'($urandom);
        k = 1; bcnt = 0; moved = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) bcnt++;
            if (bus.bcd !== shown_bcd || bus.digit_en !== shown_en) moved = 1;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k - 1 !== 17) $display("FAIL %s latency: got %0d edges, want 17", name, k - 1);
        else passes++;
        checks++;
        if (bcnt !== 17) $display("FAIL %s busy_cycles: got %0d, want 17", name, bcnt);
        else passes++;
        checks++;
        if (moved) $display("FAIL %s held_result: bcd/digit_en changed before done, want %h/%b", name, shown_bcd, shown_en);
        else passes++;
        checks++;
        if (bus.bcd !== ref_bcd(v)) $display("FAIL %s bcd: got %h, want %h", name, bus.bcd, ref_bcd(v));
        else passes++;
        checks++;
        if (bus.digit_en !== ref_en(v)) $display("FAIL %s digit_en: got %b, want %b", name, bus.digit_en, ref_en(v));
        else passes++;
        shown_bcd = ref_bcd(v);
        shown_en  = ref_en(v);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) $display("FAIL %s done_width: got done=%b one cycle later, want 0", name, bus.done);
        else passes++;
    endtask

    task automatic test_reset();
        clrn      = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset busy_done: got %b, want 00", {bus.busy, bus.done});
        else passes++;
        checks++;
        if (bus.bcd !== '0) $display("FAIL reset bcd: got %h, want 00000", bus.bcd);
        else passes++;
        checks++;
        if (bus.digit_en !== EN_RST) $display("FAIL reset digit_en: got %b, want %b", bus.digit_en, EN_RST);
        else passes++;
        clrn      = 1'b1;
        shown_bcd = '0;
        shown_en  = EN_RST;
    endtask

    task automatic test_corners();
        run_one("zero", 16'd0);
        run_one("max", 16'hFFFF);
        run_one("v1234", 16'd1234);
    endtask

    task automatic test_ignore_start();
        int pulses;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd500;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) $display("FAIL ignore pulses: got %0d done pulses, want 1", pulses);
        else passes++;
        checks++;
        if (bus.bcd !== ref_bcd(99)) $display("FAIL ignore bcd: got %h, want %h", bus.bcd, ref_bcd(99));
        else passes++;
        shown_bcd = ref_bcd(99);
        shown_en  = ref_en(99);
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd4321;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL abort busy_done: got %b, want 00", {bus.busy, bus.done});
        else passes++;
        checks++;
        if (bus.bcd !== '0) $display("FAIL abort bcd: got %h, want 00000", bus.bcd);
        else passes++;
        clrn   = 1'b1;
        pulses = 0;
        repeat (30) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) $display("FAIL abort no_done: got %0d done pulses, want 0", pulses);
        else passes++;
        shown_bcd = '0;
        shown_en  = EN_RST;
        run_one("after_abort", 16'd7);
    endtask

    task automatic test_back_to_back();
        int k, t1, t2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 16'd10;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 60);
        t1 = k;
        checks++;
        if (bus.bcd !== ref_bcd(10)) $display("FAIL b2b first_bcd: got %h, want %h", bus.bcd, ref_bcd(10));
        else passes++;
        bus.bin = 16'd20;
        @(negedge clk);
        k++;
        bus.start = 1'b0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        t2 = k;
        checks++;
        if (t2 - t1 !== 18) $display("FAIL b2b gap: got %0d cycles between done pulses, want 18", t2 - t1);
        else passes++;
        checks++;
        if (bus.bcd !== ref_bcd(20)) $display("FAIL b2b second_bcd: got %h, want %h", bus.bcd, ref_bcd(20));
        else passes++;
        checks++;
        if (bus.digit_en !== ref_en(20)) $display("FAIL b2b digit_en: got %b, want %b", bus.digit_en, ref_en(20));
        else passes++;
        shown_bcd = ref_bcd(20);
        shown_en  = ref_en(20);
    endtask

    task automatic test_random();
        logic [BIN_W-1:0] edge_vals [6] = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000};
        foreach (edge_vals[i]) run_one("boundary", edge_vals[i]);
        repeat (20) run_one("random", 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_corners();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
